// File: rtl/arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : arbiter4
// Purpose  : Four-requester round-robin arbiter with a bounded hold time and a
//            registered shared data path (q follows the owner one cycle late).
// Revision : 1.0 - initial release
// ============================================================================
module arbiter4 #(
  parameter int DATAWIDTH = 8,
  parameter int HOLD      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [DATAWIDTH-1:0] d0,
  input  logic [DATAWIDTH-1:0] d1,
  input  logic [DATAWIDTH-1:0] d2,
  input  logic [DATAWIDTH-1:0] d3,
  output logic [3:0]           grant,
  output logic [1:0]           select,
  output logic                 busy,
  output logic [DATAWIDTH-1:0] q,
  output logic                 q_valid
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  localparam logic [7:0] C_HOLD = 8'(HOLD);

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [3:0]           grant_q, grant_d;
  logic [DATAWIDTH-1:0] q_q;
  logic                 qv_q;
  logic [3:0]           w_others;
  logic [DATAWIDTH-1:0] w_data;

  // First set bit of mask scanning ptr+1, ptr+2, ptr+3, ptr (wrapping 3->0).
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] mask);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  // Shared 4:1 data mux steered by the registered owner index.
  always_comb begin
    w_data = d0;
    case (sel_q)
      2'd0: w_data = d0;
      2'd1: w_data = d1;
      2'd2: w_data = d2;
      2'd3: w_data = d3;
      default: w_data = d0;
    endcase
  end

  // Next-state: ownership, rotation pointer, hold counter and grant vector.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    w_others = req & ~(4'b0001 << sel_q);
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_OWNED;
          sel_d   = rr_pick(ptr_q, req);
          cnt_d   = 8'd1;
        end
      end
      ST_OWNED: begin
        if (req[sel_q]) begin
          if (cnt_q < C_HOLD) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            // Hold expired: hand over if anyone else waits, else restart tenure.
            cnt_d = 8'd1;
            if (|w_others) begin
              ptr_d = sel_q;
              sel_d = rr_pick(sel_q, w_others);
            end
          end
        end else begin
          ptr_d = sel_q;
          if (|req) begin
            sel_d = rr_pick(sel_q, req);
            cnt_d = 8'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    grant_d = (state_d == ST_OWNED) ? (4'b0001 << sel_d) : 4'b0000;
  end

  // State and data registers; reset drops any ownership immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= 8'd0;
      grant_q <= 4'b0000;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      if (state_q == ST_OWNED) begin
        q_q  <= w_data;
        qv_q <= 1'b1;
      end else begin
        qv_q <= 1'b0;
      end
    end
  end

  assign grant   = grant_q;
  assign select  = sel_q;
  assign busy    = (state_q == ST_OWNED);
  assign q       = q_q;
  assign q_valid = qv_q;

endmodule
`default_nettype wire

// File: tb/tb_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter4
// Purpose  : Self-checking bench for arbiter4 against a behavioural model of
//            round-robin service with bounded tenure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter4;

  localparam int DW   = 8;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [DW-1:0] dv [4];
  logic [3:0]    grant;
  logic [1:0]    select;
  logic          busy;
  logic [DW-1:0] q;
  logic          q_valid;

  int n_pass = 0;
  int n_total = 0;

  // Model: who owns the bus, how long they have held it, who last released it.
  int            m_owner;
  int            m_last;
  int            m_tenure;
  int            m_sel;
  logic [DW-1:0] m_q;
  logic          m_qv;
  int            streak;

  arbiter4 #(.DATAWIDTH(DW), .HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .grant(grant), .select(select), .busy(busy), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Next owner: the first requester found walking upward from 'start', wrapping.
  function automatic int next_in_turn(input int start, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model by one edge, clock the DUT, then compare everything.
  task automatic step();
    logic [3:0] others;
    logic [3:0] prev_grant;
    prev_grant = grant;
    if (reset) begin
      m_owner = -1; m_last = 3; m_tenure = 0; m_sel = 0; m_q = '0; m_qv = 1'b0;
    end else begin
      if (m_owner >= 0) begin m_q = dv[m_owner]; m_qv = 1'b1; end
      else m_qv = 1'b0;
      if (m_owner < 0) begin
        if (req != 0) begin m_owner = next_in_turn(m_last, req); m_tenure = 1; end
      end else if (req[m_owner]) begin
        others = req;
        others[m_owner] = 1'b0;
        if (m_tenure < HOLD) m_tenure++;
        else begin
          m_tenure = 1;
          if (others != 0) begin m_last = m_owner; m_owner = next_in_turn(m_owner, others); end
        end
      end else begin
        m_last = m_owner;
        if (req != 0) begin m_owner = next_in_turn(m_owner, req); m_tenure = 1; end
        else m_owner = -1;
      end
      if (m_owner >= 0) m_sel = m_owner;
    end
    others = req & ~prev_grant;
    @(posedge clk);
    #1;
    if (grant != 0 && grant == prev_grant && !reset) streak = (others != 0) ? streak + 1 : 1;
    else streak = (grant != 0) ? 1 : 0;
    check("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("select", select, m_sel);
    check("busy", busy, m_owner >= 0);
    check("q_valid", q_valid, m_qv);
    check("q", q, m_q);
    check("onehot", $countones(grant) <= 1, 1);
    if (busy) check("decode", grant, 32'd1 << select);
    check("hold_bound", streak <= HOLD, 1);
  endtask

  initial begin
    reset = 1'b1; req = 4'b0000;
    for (int i = 0; i < 4; i++) dv[i] = 8'(i * 16 + 3);
    streak = 0;
    m_owner = -1; m_last = 3; m_tenure = 0; m_sel = 0; m_q = '0; m_qv = 1'b0;
    @(negedge clk);
    step(); step();
    check("reset_grant", grant, 0);
    check("reset_q", q, 0);

    // All four request continuously: 0,1,2,3,0 each for HOLD cycles.
    reset = 1'b0; req = 4'b1111;
    for (int i = 1; i <= 20; i++) begin
      for (int j = 0; j < 4; j++) dv[j] = 8'($urandom);
      step();
      check("rr_seq", grant, 32'd1 << (((i - 1) / HOLD) % 4));
      check("rr_busy", busy, 1);
    end

    // Lone requester 2 keeps the bus; q shows its data a cycle later.
    req = 4'b0100; dv[2] = 8'hA5;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("solo_grant", grant, 4'b0100);
      if (i > 1) check("solo_q", q, 8'hA5);
    end

    // Owner 1 drops while 3 waits: handover with no idle bubble.
    req = 4'b0000; step();
    req = 4'b0010; step(); step();
    req = 4'b1010; step();
    check("no_preempt", grant, 4'b0010);
    req = 4'b1000; step();
    check("handover", grant, 4'b1000);
    check("handover_busy", busy, 1);

    // Owner 0 drops with nobody else asking: bus goes idle, select stays 0.
    req = 4'b0001; step();
    check("own0", grant, 4'b0001);
    req = 4'b0000; step();
    check("idle_busy", busy, 0);
    check("idle_sel", select, 0);
    step();
    check("idle_qv", q_valid, 0);

    // Reset mid-tenure, then 0 and 2 compete: 0 wins after reset.
    req = 4'b0100; step(); step();
    reset = 1'b1; step();
    check("rst_mid_grant", grant, 0);
    check("rst_mid_q", q, 0);
    reset = 1'b0; req = 4'b0101; step();
    check("post_rst_first", grant, 4'b0001);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) dv[j] = 8'($urandom);
      if ($urandom_range(0, 9) < 7) req = 4'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arbiter4.md
ARBITER4 -- requirements
Module: arbiter4

Interface
REQ-001 Parameter: DATAWIDTH, 8, width of each requester data bus and of q.
REQ-002 Parameter: HOLD, 4, maximum consecutive grant cycles while another requester waits; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  4  request lines, bit n = requester n.
REQ-006 Port: d0, d1, d2, d3  input  DATAWIDTH each  requester data.
REQ-007 Port: grant  output  4  registered one-hot grant; all zero when idle.
REQ-008 Port: select  output  2  registered binary index of the owner; drives the shared 4:1 data mux.
REQ-009 Port: busy  output  1  registered; high exactly when grant is non-zero.
REQ-010 Port: q  output  DATAWIDTH  registered copy of the granted requester's data.
REQ-011 Port: q_valid  output  1  registered; high when q holds data captured under a grant.

Function
REQ-012 States: IDLE (no owner), OWNED (one owner). Internal state: last-owner pointer (2 bits) and hold counter (8 bits).
REQ-013 grant shall always equal the 2-to-4 decode of select when busy=1, and 4'b0000 when busy=0.
REQ-014 Priority order: round-robin starting at pointer+1 modulo 4, wrapping 3->0.
REQ-015 IDLE, req=0: stay IDLE; outputs unchanged.
REQ-016 IDLE, req!=0: next edge enter OWNED with select = round-robin winner, busy=1, counter=1; latency req->grant = 1 cycle.
REQ-017 OWNED, req[select]=1, counter<HOLD: keep owner; counter increments.
REQ-018 OWNED, req[select]=1, counter>=HOLD, other req bits set: forced release; same edge grants the round-robin winner excluding the old owner; pointer=old owner; counter=1; no idle bubble.
REQ-019 OWNED, req[select]=1, counter>=HOLD, no other req: keep owner; counter reloads to 1.
REQ-020 OWNED, req[select]=0, other req bits set: pointer=old owner; next edge grants round-robin winner, counter=1; no bubble.
REQ-021 OWNED, req=0: pointer=old owner; next edge enter IDLE, busy=0, grant=0; select keeps its last value.
REQ-022 Requests from non-owners never preempt the owner before HOLD expires.
REQ-023 Counter saturates at HOLD; never wraps.
REQ-024 Data path: every edge where busy=1 (pre-edge), q <= data of requester select (pre-edge), q_valid <= 1; otherwise q holds, q_valid <= 0.
REQ-025 q therefore lags grant by exactly one cycle; data sampled in the cycle grant is visible.
REQ-026 Simultaneous request by all four from IDLE at reset state: order of service is 0,1,2,3,0...

Reset
REQ-027 reset=1 at an edge: state IDLE, grant=0, select=0, busy=0, q=0, q_valid=0, counter=0, pointer=3 (requester 0 wins first).
REQ-028 Reset overrides every other condition including mid-grant and forced release; an ownership in progress is dropped without a release cycle.
REQ-029 First arbitration occurs on the first edge with reset=0 and req!=0.

Verification
REQ-030 After reset, req=4'b1111 held, HOLD=4: grant 0001 for 4 cycles, then 0010, 0100, 1000, 0001, each 4 cycles, busy constant 1.
REQ-031 req=4'b0100 alone for 10 cycles, d2=8'hA5: grant 0100 continuous, select=2, q=8'hA5 and q_valid=1 from the cycle after grant.
REQ-032 Owner 1 drops req while req[3]=1: grant 0010 -> 1000 on the next edge, no cycle with busy=0.
REQ-033 Single owner 0 drops req, req=0: one edge later busy=0, grant=0, select=0, q_valid=0 following cycle.
REQ-034 reset pulsed while grant=0100 with counter=2: next cycle grant=0, q=0; with req=4'b0101 afterwards, requester 0 granted first.
REQ-035 Continuous check: grant one-hot or zero, grant==decode(select) when busy, no owner exceeds HOLD cycles while another req is pending.
